// File: rtl/mesh_l2_axi_mem.sv
// mesh_l2_axi_mem: AXI4 slave memory standing in for the L2 behind the mesh NoC.
// Optional: define MESH_L2_MEM_ERR_EN to flag out-of-range beats with SLVERR instead of aliasing.
package mesh_l2_axi_pkg;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 8;
   localparam int unsigned USER_W = 1;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic [USER_W-1:0] user;
   } ax_chan_t;

   typedef struct packed {
      logic [DATA_W-1:0]   data;
      logic [DATA_W/8-1:0] strb;
      logic                last;
      logic [USER_W-1:0]   user;
   } w_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [1:0]        resp;
      logic [USER_W-1:0] user;
   } b_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      logic              last;
      logic [USER_W-1:0] user;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_rsp_t;
endpackage

module mesh_l2_axi_mem #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ID_W      = 8,
   parameter int unsigned       USER_W    = 1,
   parameter int unsigned       MEM_BYTES = 65536,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000_0000,
   parameter int unsigned       RD_LAT    = 0,
   parameter type               axi_req_t = mesh_l2_axi_pkg::axi_req_t,
   parameter type               axi_rsp_t = mesh_l2_axi_pkg::axi_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  axi_req_t axi_req_i,
   output axi_rsp_t axi_rsp_o
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned WORDS  = MEM_BYTES / STRB_W;
   localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  BURST_FIXED = 2'b00;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

   logic [DATA_W-1:0] mem_q [WORDS];

   // Word index wraps modulo the word count, so out-of-window addresses alias.
   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE_ADDR;
      return IDX_W'((off >> OFF_W) % WORDS);
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] off;
      off = {1'b0, a} - {1'b0, BASE_ADDR};
      return (a >= BASE_ADDR) && (off < (ADDR_W+1)'(MEM_BYTES));
   endfunction

   // WRAP bursts deliberately follow the INCR rule.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] size,
                                                   input logic [1:0] burst);
      logic [ADDR_W-1:0] step;
      step = ADDR_W'(1) << size;
      if (burst == BURST_FIXED) return a;
      return (a + step) & ~(step - ADDR_W'(1));
   endfunction

   logic              en_q;
   w_state_e          w_state_q, w_state_d;
   logic [ID_W-1:0]   wid_q, wid_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic [2:0]        wsize_q, wsize_d;
   logic [1:0]        wburst_q, wburst_d;
   logic              werr_q, werr_d;
   logic              w_ok, mem_we, aw_ready, w_ready, b_valid;

   r_state_e          r_state_q, r_state_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d, raddr_nxt, rd_addr;
   logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d, rcnt_q, rcnt_d;
   logic [2:0]        rsize_q, rsize_d;
   logic [1:0]        rburst_q, rburst_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic              rd_load, ar_ready, r_valid, r_last;

   logic unused_req;
   assign unused_req = ^{axi_req_i.aw.user, axi_req_i.ar.user, axi_req_i.w.last, axi_req_i.w.user};

   always_comb begin
      w_state_d = w_state_q;
      wid_d     = wid_q;
      waddr_d   = waddr_q;
      wlen_d    = wlen_q;
      wbeat_d   = wbeat_q;
      wsize_d   = wsize_q;
      wburst_d  = wburst_q;
      werr_d    = werr_q;
      aw_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      mem_we    = 1'b0;
      w_ok      = 1'b1;
`ifdef MESH_L2_MEM_ERR_EN
      w_ok      = in_range(waddr_q);
`endif
      case (w_state_q)
         W_IDLE: begin
            aw_ready = en_q;
            if (en_q && axi_req_i.aw_valid) begin
               wid_d     = axi_req_i.aw.id;
               waddr_d   = axi_req_i.aw.addr;
               wlen_d    = axi_req_i.aw.len;
               wsize_d   = axi_req_i.aw.size;
               wburst_d  = axi_req_i.aw.burst;
               wbeat_d   = '0;
               werr_d    = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            w_ready = 1'b1;
            if (axi_req_i.w_valid) begin
               mem_we  = w_ok;
               werr_d  = werr_q | ~w_ok;
               wbeat_d = wbeat_q + 8'd1;
               waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
               if (wbeat_q == wlen_q) w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (axi_req_i.b_ready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      raddr_d   = raddr_q;
      rlen_d    = rlen_q;
      rbeat_d   = rbeat_q;
      rsize_d   = rsize_q;
      rburst_d  = rburst_q;
      rcnt_d    = rcnt_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      ar_ready  = 1'b0;
      r_valid   = 1'b0;
      r_last    = 1'b0;
      rd_load   = 1'b0;
      raddr_nxt = next_addr(raddr_q, rsize_q, rburst_q);
      rd_addr   = raddr_q;
      case (r_state_q)
         R_IDLE: begin
            ar_ready = en_q;
            if (en_q && axi_req_i.ar_valid) begin
               rid_d     = axi_req_i.ar.id;
               raddr_d   = axi_req_i.ar.addr;
               rlen_d    = axi_req_i.ar.len;
               rsize_d   = axi_req_i.ar.size;
               rburst_d  = axi_req_i.ar.burst;
               rbeat_d   = '0;
               rcnt_d    = 8'(RD_LAT);
               r_state_d = R_WAIT;
            end
         end
         R_WAIT: begin
            if (rcnt_q == '0) begin
               rd_load   = 1'b1;
               r_state_d = R_DATA;
            end else begin
               rcnt_d = rcnt_q - 8'd1;
            end
         end
         R_DATA: begin
            r_valid = 1'b1;
            r_last  = (rbeat_q == rlen_q);
            if (axi_req_i.r_ready) begin
               if (r_last) begin
                  r_state_d = R_IDLE;
               end else begin
                  rd_load = 1'b1;
                  rd_addr = raddr_nxt;
                  raddr_d = raddr_nxt;
                  rbeat_d = rbeat_q + 8'd1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      // Data is captured into a register, so a same-edge write is not seen and R stays stable.
      if (rd_load) begin
         rdata_d = mem_q[word_idx(rd_addr)];
         rresp_d = RESP_OKAY;
`ifdef MESH_L2_MEM_ERR_EN
         if (!in_range(rd_addr)) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
         end
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q      <= 1'b0;
         w_state_q <= W_IDLE;
         wid_q     <= '0;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wbeat_q   <= '0;
         wsize_q   <= '0;
         wburst_q  <= '0;
         werr_q    <= 1'b0;
         r_state_q <= R_IDLE;
         rid_q     <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rbeat_q   <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
         rcnt_q    <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         en_q      <= 1'b1;
         w_state_q <= w_state_d;
         wid_q     <= wid_d;
         waddr_q   <= waddr_d;
         wlen_q    <= wlen_d;
         wbeat_q   <= wbeat_d;
         wsize_q   <= wsize_d;
         wburst_q  <= wburst_d;
         werr_q    <= werr_d;
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         raddr_q   <= raddr_d;
         rlen_q    <= rlen_d;
         rbeat_q   <= rbeat_d;
         rsize_q   <= rsize_d;
         rburst_q  <= rburst_d;
         rcnt_q    <= rcnt_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (axi_req_i.w.strb[b]) mem_q[word_idx(waddr_q)][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
         end
      end
   end

   always_comb begin
      axi_rsp_o          = '0;
      axi_rsp_o.aw_ready = aw_ready;
      axi_rsp_o.w_ready  = w_ready;
      axi_rsp_o.b_valid  = b_valid;
      axi_rsp_o.b.id     = wid_q;
      axi_rsp_o.b.resp   = werr_q ? RESP_SLVERR : RESP_OKAY;
      axi_rsp_o.ar_ready = ar_ready;
      axi_rsp_o.r_valid  = r_valid;
      axi_rsp_o.r.id     = rid_q;
      axi_rsp_o.r.data   = rdata_q;
      axi_rsp_o.r.resp   = rresp_q;
      axi_rsp_o.r.last   = r_last;
   end
endmodule

// File: tb/tb_mesh_l2_axi_mem.sv
// Directed and randomized checks of mesh_l2_axi_mem against a byte-level memory model.
module tb_mesh_l2_axi_mem;
   import mesh_l2_axi_pkg::*;

   localparam int unsigned RD_LAT    = 5;
   localparam int unsigned MEM_BYTES = 65536;
   localparam int unsigned WORDS     = MEM_BYTES / 4;
   localparam logic [31:0] BASE      = 32'h1000_0000;
`ifdef MESH_L2_MEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic     clk = 1'b0;
   logic     rst_n = 1'b0;
   axi_req_t req;
   axi_rsp_t rsp;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0]  mdl [int];
   logic [31:0] wq_data [$];
   logic [3:0]  wq_strb [$];
   logic [31:0] rd_q [$];
   logic [1:0]  last_bresp;

   always #5 clk = ~clk;

   mesh_l2_axi_mem #(.RD_LAT(RD_LAT), .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)) dut (
      .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req), .axi_rsp_o(rsp));

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < MEM_BYTES);
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'(((a - BASE) >> 2) % WORDS);
   endfunction

   // Beat i address: FIXED repeats the start; INCR/WRAP step from the size-aligned start.
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                             input logic [2:0] size, input logic [1:0] burst);
      int unsigned sz;
      sz = 1 << size;
      if (burst == 2'b00 || i == 0) return start;
      return (start / sz) * sz + i * sz;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [31:0] w;
      int wi;
      w = '0;
      if (ERR_EN && !in_rng(a)) return w;
      wi = word_of(a);
      for (int b = 0; b < 4; b++) if (mdl.exists(wi*4+b)) w[8*b +: 8] = mdl[wi*4+b];
      return w;
   endfunction

   task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] id);
      int n;
      bit err;
      logic [31:0] ba;
      req.aw.id = id; req.aw.addr = addr; req.aw.len = 8'(len);
      req.aw.size = size; req.aw.burst = burst; req.aw_valid = 1'b1;
      n = 0;
      while (!rsp.aw_ready && n < 200) begin step(); n++; end
      chk("aw_timeout", 64'(n < 200), 64'd1);
      step();
      req.aw_valid = 1'b0;
      chk("wready_after_aw", 64'(rsp.w_ready), 64'd1);
      chk("awready_busy", 64'(rsp.aw_ready), 64'd0);
      err = 1'b0;
      for (int i = 0; i <= len; i++) begin
         if ($urandom_range(3) == 0) begin req.w_valid = 1'b0; step(); end
         ba = beat_addr(addr, i, size, burst);
         req.w.data = wq_data[i]; req.w.strb = wq_strb[i];
         req.w.last = (i == len); req.w_valid = 1'b1;
         step();
         if (!ERR_EN || in_rng(ba)) begin
            for (int b = 0; b < 4; b++)
               if (wq_strb[i][b]) mdl[word_of(ba)*4+b] = wq_data[i][8*b +: 8];
         end else begin
            err = 1'b1;
         end
      end
      req.w_valid = 1'b0;
      chk("bvalid_after_last_w", 64'(rsp.b_valid), 64'd1);
      chk("bid", 64'(rsp.b.id), 64'(id));
      chk("bresp", 64'(rsp.b.resp), err ? 64'd2 : 64'd0);
      last_bresp = rsp.b.resp;
      repeat ($urandom_range(2)) begin
         step();
         chk("bvalid_hold", 64'(rsp.b_valid), 64'd1);
      end
      req.b_ready = 1'b1;
      step();
      req.b_ready = 1'b0;
      chk("bvalid_drop", 64'(rsp.b_valid), 64'd0);
      chk("awready_back", 64'(rsp.aw_ready), 64'd1);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] id);
      int n;
      logic [31:0] ba;
      req.ar.id = id; req.ar.addr = addr; req.ar.len = 8'(len);
      req.ar.size = size; req.ar.burst = burst; req.ar_valid = 1'b1;
      n = 0;
      while (!rsp.ar_ready && n < 200) begin step(); n++; end
      chk("ar_timeout", 64'(n < 200), 64'd1);
      step();
      req.ar_valid = 1'b0;
      chk("arready_busy", 64'(rsp.ar_ready), 64'd0);
      n = 0;
      while (!rsp.r_valid && n < 300) begin step(); n++; end
      chk("r_latency", 64'(n), 64'(RD_LAT + 1));
      rd_q.delete();
      if (!rsp.r_valid) return;
      for (int i = 0; i <= len; i++) begin
         ba = beat_addr(addr, i, size, burst);
         req.r_ready = ($urandom_range(2) != 0);
         for (int k = 0; k < 3 && !req.r_ready; k++) begin
            chk("rvalid_hold", 64'(rsp.r_valid), 64'd1);
            chk("rdata_hold", 64'(rsp.r.data), 64'(exp_word(ba)));
            step();
            req.r_ready = ($urandom_range(1) != 0);
         end
         req.r_ready = 1'b1;
         chk("rvalid", 64'(rsp.r_valid), 64'd1);
         chk("rdata", 64'(rsp.r.data), 64'(exp_word(ba)));
         chk("rlast", 64'(rsp.r.last), 64'(i == len));
         chk("rid", 64'(rsp.r.id), 64'(id));
         chk("rresp", 64'(rsp.r.resp), (ERR_EN && !in_rng(ba)) ? 64'd2 : 64'd0);
         rd_q.push_back(rsp.r.data);
         step();
      end
      req.r_ready = 1'b0;
      chk("rvalid_drop", 64'(rsp.r_valid), 64'd0);
      chk("arready_back", 64'(rsp.ar_ready), 64'd1);
   endtask

   task automatic fill(input int n, input logic [3:0] strb);
      wq_data.delete(); wq_strb.delete();
      for (int i = 0; i < n; i++) begin
         wq_data.push_back($urandom);
         wq_strb.push_back(strb == 4'h0 ? 4'($urandom_range(15)) : strb);
      end
   endtask

   initial begin
      logic [31:0] old_w, addr;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          n, len;
      req = '0;
      repeat (3) step();
      chk("rst_awready", 64'(rsp.aw_ready), 64'd0);
      chk("rst_wready", 64'(rsp.w_ready), 64'd0);
      chk("rst_bvalid", 64'(rsp.b_valid), 64'd0);
      chk("rst_arready", 64'(rsp.ar_ready), 64'd0);
      chk("rst_rvalid", 64'(rsp.r_valid), 64'd0);
      chk("rst_rfields", 64'({rsp.r.data, rsp.r.id, rsp.r.resp, rsp.r.last}), 64'd0);
      chk("rst_bfields", 64'({rsp.b.id, rsp.b.resp}), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("awready_pre_edge", 64'(rsp.aw_ready), 64'd0);
      step();
      chk("awready_post_rst", 64'(rsp.aw_ready), 64'd1);
      chk("arready_post_rst", 64'(rsp.ar_ready), 64'd1);

      // Preload words 0..63 so every later read hits known bytes.
      fill(64, 4'hF);
      axi_write(BASE, 63, 3'd2, 2'b01, 8'h11);

      wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
      axi_write(BASE, 0, 3'd2, 2'b01, 8'h21);
      chk("t1_bresp", 64'(last_bresp), 64'd0);
      axi_read(BASE, 0, 3'd2, 2'b01, 8'h22);
      chk("t1_rdata", 64'(rd_q[0]), 64'h0000_0000_DEAD_BEEF);

      wq_data = '{32'd1, 32'd2, 32'd3, 32'd4}; wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
      axi_write(BASE + 32'h10, 3, 3'd2, 2'b01, 8'h31);
      axi_read(BASE + 32'h10, 3, 3'd2, 2'b01, 8'h32);
      for (int i = 0; i < 4; i++) chk("t2_incr_data", 64'(rd_q[i]), 64'(i + 1));

      wq_data = '{32'hFFFF_FFFF}; wq_strb = '{4'hF};
      axi_write(BASE + 32'h20, 0, 3'd2, 2'b01, 8'h41);
      wq_data = '{32'h1122_3344}; wq_strb = '{4'b0101};
      axi_write(BASE + 32'h20, 0, 3'd2, 2'b01, 8'h42);
      axi_read(BASE + 32'h20, 0, 3'd2, 2'b01, 8'h43);
      chk("t3_strobe", 64'(rd_q[0]), 64'h0000_0000_FF22_FF44);

      // W beat and R capture share one edge: R must carry the pre-write word.
      old_w = exp_word(BASE + 32'h40);
      req.aw = '0; req.aw.id = 8'h51; req.aw.addr = BASE + 32'h40; req.aw.size = 3'd2;
      req.aw.burst = 2'b01; req.aw_valid = 1'b1;
      step();
      req.aw_valid = 1'b0;
      req.ar = '0; req.ar.id = 8'h52; req.ar.addr = BASE + 32'h40; req.ar.size = 3'd2;
      req.ar.burst = 2'b01; req.ar_valid = 1'b1;
      step();
      req.ar_valid = 1'b0;
      repeat (RD_LAT) step();
      req.w.data = 32'hCAFE_F00D; req.w.strb = 4'hF; req.w.last = 1'b1; req.w_valid = 1'b1;
      step();
      req.w_valid = 1'b0;
      for (int b = 0; b < 4; b++) mdl[word_of(BASE + 32'h40)*4+b] = 8'(32'hCAFE_F00D >> (8*b));
      chk("t4_rvalid", 64'(rsp.r_valid), 64'd1);
      chk("t4_old_data", 64'(rsp.r.data), 64'(old_w));
      chk("t4_bvalid", 64'(rsp.b_valid), 64'd1);
      req.b_ready = 1'b1; req.r_ready = 1'b1;
      step();
      req.b_ready = 1'b0; req.r_ready = 1'b0;
      axi_read(BASE + 32'h40, 0, 3'd2, 2'b01, 8'h53);
      chk("t4_new_data", 64'(rd_q[0]), 64'h0000_0000_CAFE_F00D);

      old_w = exp_word(BASE);
      wq_data = '{32'hA5A5_5A5A}; wq_strb = '{4'hF};
      axi_write(BASE + MEM_BYTES, 0, 3'd2, 2'b01, 8'h61);
      axi_read(BASE, 0, 3'd2, 2'b01, 8'h62);
`ifdef MESH_L2_MEM_ERR_EN
      chk("t5_oor_bresp", 64'(last_bresp), 64'd2);
      chk("t5_base_kept", 64'(rd_q[0]), 64'(old_w));
`else
      chk("t5_alias_bresp", 64'(last_bresp), 64'd0);
      chk("t5_alias_data", 64'(rd_q[0]), 64'h0000_0000_A5A5_5A5A);
`endif

      req.ar = '0; req.ar.addr = BASE + 32'h10; req.ar.len = 8'd3; req.ar.size = 3'd2;
      req.ar.burst = 2'b01; req.ar_valid = 1'b1;
      step();
      req.ar_valid = 1'b0;
      n = 0;
      while (!rsp.r_valid && n < 300) begin step(); n++; end
      chk("t6_first_beat", 64'(rsp.r_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rvalid_rst", 64'(rsp.r_valid), 64'd0);
      step();
      chk("t6_rvalid_edge", 64'(rsp.r_valid), 64'd0);
      chk("t6_arready_rst", 64'(rsp.ar_ready), 64'd0);
      rst_n = 1'b1;
      step();
      chk("t6_arready_rel", 64'(rsp.ar_ready), 64'd1);
      axi_read(BASE + 32'h10, 3, 3'd2, 2'b01, 8'h71);
      for (int i = 0; i < 4; i++) chk("t6_reread", 64'(rd_q[i]), 64'(i + 1));

      for (int k = 0; k < 30; k++) begin
         size  = 3'($urandom_range(2));
         burst = 2'($urandom_range(2));
         len   = int'($urandom_range(15));
         addr  = BASE + 32'($urandom_range(47)) * 4 + 32'($urandom_range(3));
         if ($urandom_range(1) == 1) begin
            fill(len + 1, 4'h0);
            axi_write(addr, len, size, burst, 8'($urandom));
         end else begin
            axi_read(addr, len, size, burst, 8'($urandom));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
